alarm_buzz_ctrl: RTL and testbench
==================================

// Module: alarm_buzz_ctrl
// PURPOSE
//  Sits directly downstream of the alarm-clock top level and consumes its raw alarm-match level.
//  The raw level is day-masked and gated by Alarmon.
//  Turns that level into a bounded ring sequence: the buzzer times out on its own and supports a
//  limited number of timed snoozes plus an explicit stop. Runs on the 1 Hz Pulse clock, so all
//  counts are in seconds.
// PARAMETERS
//  RING_SEC    60   cycles the buzzer sounds per ring episode before auto-silence
//  SNOOZE_SEC  300  cycles of silence per snooze before re-ring
//  MAX_SNOOZE  3    snoozes allowed per alarm event; further snooze presses are ignored
// PORTS
//  clk           in   1    1 Hz Pulse; single clock domain
//  rst           in   1    asynchronous, active-high reset
//  buzz_req      in   1    alarm-match level from top level; high for the whole matching minute
//  alarm_on      in   1    master enable (Alarmon switch)
//  snooze        in   1    snooze button, level, sampled each clk
//  stop          in   1    stop button, level, sampled each clk
//  buzz          out  1    drive to buzzer
//  snoozing      out  1    high while in SNOOZE
//  snooze_left   out  $clog2(SNOOZE_SEC+1)  seconds remaining in the current snooze; 0 outside SNOOZE
//  snoozes_used  out  $clog2(MAX_SNOOZE+1)  snoozes taken in the current event
// BEHAVIOUR
//  - Reset (async): state=IDLE, all counters 0, req_d=1, and every output 0.
//    req_d=1 suppresses a ring when buzz_req is already high at reset release.
//  - req_d registers buzz_req every cycle. trigger = buzz_req & ~req_d, i.e. the rising edge only,
//    so a stopped alarm never re-fires within the same matching minute.
//  - Moore outputs are decoded from registered state. buzz = (state==RING), snoozing = (state==SNOOZE).
//    Latency is 1 clk: outputs change after the edge that samples the cause.
//  - IDLE:
//    - trigger & alarm_on -> RING; ring_ct=0, snz_used=0.
//    - Otherwise stay.
//  - RING: checked in this priority order.
//    1. stop | ~alarm_on -> IDLE.
//    2. snooze & snz_used<MAX_SNOOZE -> SNOOZE; snz_ct=SNOOZE_SEC-1, snz_used+1.
//    3. ring_ct==RING_SEC-1 -> IDLE (timeout).
//    4. Otherwise ring_ct+1.
//    - A snooze press with snz_used==MAX_SNOOZE is ignored; the ring continues.
//    - Each ring episode lasts exactly RING_SEC cycles absent other events.
//  - SNOOZE: checked in this priority order.
//    1. stop | ~alarm_on -> IDLE.
//    2. snz_ct==0 -> RING; ring_ct=0.
//    3. Otherwise snz_ct-1.
//    - Snooze presses are ignored here. Snooze lasts exactly SNOOZE_SEC cycles.
//    - New triggers are ignored in SNOOZE and RING.
//  - snooze_left = snz_ct in SNOOZE, else 0.
//  - snoozes_used holds its value through IDLE until the next trigger clears it.
//  - Simultaneous stop+snooze: stop wins.
//  - Trigger in the same cycle as alarm_on=0: no ring.
//  - Counters saturate-free by construction: they never exceed N-1.
//  - Reset mid-RING/SNOOZE forces outputs 0 immediately, without waiting for clk.
// STRUCTURE
//  - alarm_pkg holds:
//    - typedef enum logic[1:0] {IDLE, RING, SNOOZE} buzz_st_t;
//    - default constants RING_SEC_D, SNOOZE_SEC_D, MAX_SNOOZE_D.
//  - One sub-module: sec_down_ct #(N). A loadable down-counter with load/en/ct_out/zero, async rst.
//    Used for snz_ct. ring_ct may reuse the existing ct_mod_N with a synchronous clear on entry.
//  - FSM and edge detect stay in this module.
// TESTING  (bench params RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2)
//  1. Assert rst mid-sim -> buzz=0, snoozing=0, snooze_left=0, snoozes_used=0 before next clk.
//     Release with buzz_req=1 held -> no ring.
//  2. alarm_on=1, buzz_req rises at edge k, held 10 cycles -> buzz=1 for edges k..k+3, then 0.
//     No re-ring while buzz_req stays high.
//  3. Ringing; snooze at 2nd ring cycle -> buzz=0, snoozing=1, snooze_left=2,1,0.
//     Then buzz=1 for 4 cycles; snoozes_used=1.
//  4. Snooze twice, then snooze a third time -> third press ignored; buzz stays 1 until timeout;
//     snoozes_used=2.
//  5. stop & snooze in the same ring cycle -> IDLE next edge; buzz=0, snoozing=0, snoozes_used unchanged.
//  6. alarm_on drops with snooze_left=1 -> IDLE, no re-ring.
//     buzz_req rises while alarm_on=0 -> no ring.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm buzzer controller.
// All durations are in seconds because the controller runs on the 1 Hz pulse clock.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RING,
        SNOOZE
    } buzz_st_t;

    localparam int RING_SEC_D   = 60;
    localparam int SNOOZE_SEC_D = 300;
    localparam int MAX_SNOOZE_D = 3;

endpackage

// File: rtl/alarm_buzz_ctrl_sec_down_ct.sv
// Loadable seconds down-counter: load presets N-1, en counts down and stops at zero.
module sec_down_ct #(
    parameter  int N = 300,
    localparam int W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    output logic [W-1:0] ct_out,
    output logic         zero
);

    logic [W-1:0] ct_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ct_reg <= '0;
        end else if (load) begin
            ct_reg <= W'(N - 1);
        end else if (en && (ct_reg != '0)) begin
            ct_reg <= ct_reg - 1'b1;
        end
    end

    assign ct_out = ct_reg;
    assign zero   = (ct_reg == '0);

endmodule

// File: rtl/alarm_buzz_ctrl.sv
// Converts the raw alarm-match level into a bounded ring sequence with timed snoozes and stop.
// Rising-edge triggered so a stopped alarm cannot re-fire within the same matching minute.
module alarm_buzz_ctrl
    import alarm_pkg::*;
#(
    parameter  int RING_SEC   = RING_SEC_D,
    parameter  int SNOOZE_SEC = SNOOZE_SEC_D,
    parameter  int MAX_SNOOZE = MAX_SNOOZE_D,
    localparam int SL_W       = $clog2(SNOOZE_SEC + 1),
    localparam int SU_W       = $clog2(MAX_SNOOZE + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            buzz_req,
    input  logic            alarm_on,
    input  logic            snooze,
    input  logic            stop,
    output logic            buzz,
    output logic            snoozing,
    output logic [SL_W-1:0] snooze_left,
    output logic [SU_W-1:0] snoozes_used
);

    localparam int RC_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;

    buzz_st_t        state_reg, state_next;
    logic [RC_W-1:0] ring_ct_reg, ring_ct_next;
    logic [SU_W-1:0] snz_used_reg, snz_used_next;
    logic            req_d_reg;
    logic            trigger;
    logic            snz_load, snz_en, snz_zero;
    logic [SL_W-1:0] snz_ct;

    sec_down_ct #(.N(SNOOZE_SEC)) u_snz_ct (
        .clk    (clk),
        .rst    (rst),
        .load   (snz_load),
        .en     (snz_en),
        .ct_out (snz_ct),
        .zero   (snz_zero)
    );

    // req_d resets high so a level already present at reset release is not seen as an edge.
    assign trigger = buzz_req & ~req_d_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            ring_ct_reg  <= '0;
            snz_used_reg <= '0;
            req_d_reg    <= 1'b1;
        end else begin
            state_reg    <= state_next;
            ring_ct_reg  <= ring_ct_next;
            snz_used_reg <= snz_used_next;
            req_d_reg    <= buzz_req;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ring_ct_next  = ring_ct_reg;
        snz_used_next = snz_used_reg;
        snz_load      = 1'b0;
        snz_en        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (trigger && alarm_on) begin
                    state_next    = RING;
                    ring_ct_next  = '0;
                    snz_used_next = '0;
                end
            end
            RING: begin
                if (stop || !alarm_on) begin
                    state_next = IDLE;
                end else if (snooze && (snz_used_reg < SU_W'(MAX_SNOOZE))) begin
                    state_next    = SNOOZE;
                    snz_load      = 1'b1;
                    snz_used_next = snz_used_reg + 1'b1;
                end else if (ring_ct_reg == RC_W'(RING_SEC - 1)) begin
                    state_next = IDLE;
                end else begin
                    ring_ct_next = ring_ct_reg + 1'b1;
                end
            end
            SNOOZE: begin
                if (stop || !alarm_on) begin
                    state_next = IDLE;
                end else if (snz_zero) begin
                    state_next   = RING;
                    ring_ct_next = '0;
                end else begin
                    snz_en = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs straight from registered state, so async reset clears them immediately.
    assign buzz         = (state_reg == RING);
    assign snoozing     = (state_reg == SNOOZE);
    assign snooze_left  = (state_reg == SNOOZE) ? snz_ct : '0;
    assign snoozes_used = snz_used_reg;

endmodule

// File: tb/tb_alarm_buzz_ctrl.sv
// Directed bench for alarm_buzz_ctrl with RING_SEC=4, SNOOZE_SEC=3, MAX_SNOOZE=2.
// Observed vector per step is {buzz, snoozing, snooze_left[1:0], snoozes_used[1:0]}.
module tb_alarm_buzz_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       buzz_req, alarm_on, snooze, stop;
    logic       buzz, snoozing;
    logic [1:0] snooze_left, snoozes_used;
    logic [5:0] obs;

    int compared   = 0;
    int mismatched = 0;

    alarm_buzz_ctrl #(
        .RING_SEC   (4),
        .SNOOZE_SEC (3),
        .MAX_SNOOZE (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .buzz_req     (buzz_req),
        .alarm_on     (alarm_on),
        .snooze       (snooze),
        .stop         (stop),
        .buzz         (buzz),
        .snoozing     (snoozing),
        .snooze_left  (snooze_left),
        .snoozes_used (snoozes_used)
    );

    always #5 clk = ~clk;

    assign obs = {buzz, snoozing, snooze_left, snoozes_used};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stimulus rows are {buzz_req, alarm_on, snooze, stop}, applied before the step's edge.
    task automatic test_reset;
        rst = 1'b1; buzz_req = 1'b1; alarm_on = 1'b1; snooze = 1'b0; stop = 1'b0;
        #2;
        compared++;
        if (obs !== 6'b00_00_00) begin
            mismatched++;
            $display("FAIL reset_state: got %b want %b", obs, 6'b00_00_00);
        end
        tick; tick;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            compared++;
            if (obs !== 6'b00_00_00) begin
                mismatched++;
                $display("FAIL reset_release_no_ring step%0d: got %b want %b", i, obs, 6'b00_00_00);
            end
        end
        buzz_req = 1'b0;
        tick;
    endtask

    task automatic test_ring_timeout;
        logic [5:0] e;
        alarm_on = 1'b1; buzz_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            e = (i < 4) ? 6'b10_00_00 : 6'b00_00_00;
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL ring_timeout step%0d: got %b want %b", i, obs, e);
            end
        end
        buzz_req = 1'b0;
        tick;
    endtask

    task automatic test_snooze;
        logic [3:0] s [10] = '{4'b1100, 4'b0100, 4'b0110, 4'b0100, 4'b0100,
                               4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
        logic [5:0] e [10] = '{6'b10_00_00, 6'b10_00_00, 6'b01_10_01, 6'b01_01_01, 6'b01_00_01,
                               6'b10_00_01, 6'b10_00_01, 6'b10_00_01, 6'b10_00_01, 6'b00_00_01};
        for (int i = 0; i < 10; i++) begin
            {buzz_req, alarm_on, snooze, stop} = s[i];
            tick;
            compared++;
            if (obs !== e[i]) begin
                mismatched++;
                $display("FAIL snooze step%0d: got %b want %b", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_snooze_limit;
        logic [3:0] s [13] = '{4'b1100, 4'b0110, 4'b0100, 4'b0100, 4'b0100, 4'b0110, 4'b0100,
                               4'b0100, 4'b0100, 4'b0110, 4'b0110, 4'b0110, 4'b0110};
        logic [5:0] e [13] = '{6'b10_00_00, 6'b01_10_01, 6'b01_01_01, 6'b01_00_01, 6'b10_00_01,
                               6'b01_10_10, 6'b01_01_10, 6'b01_00_10, 6'b10_00_10, 6'b10_00_10,
                               6'b10_00_10, 6'b10_00_10, 6'b00_00_10};
        for (int i = 0; i < 13; i++) begin
            {buzz_req, alarm_on, snooze, stop} = s[i];
            tick;
            compared++;
            if (obs !== e[i]) begin
                mismatched++;
                $display("FAIL snooze_limit step%0d: got %b want %b", i, obs, e[i]);
            end
        end
        snooze = 1'b0;
    endtask

    task automatic test_stop_snooze;
        logic [3:0] s [7] = '{4'b1100, 4'b0110, 4'b0100, 4'b0100, 4'b0100, 4'b0111, 4'b0100};
        logic [5:0] e [7] = '{6'b10_00_00, 6'b01_10_01, 6'b01_01_01, 6'b01_00_01,
                              6'b10_00_01, 6'b00_00_01, 6'b00_00_01};
        for (int i = 0; i < 7; i++) begin
            {buzz_req, alarm_on, snooze, stop} = s[i];
            tick;
            compared++;
            if (obs !== e[i]) begin
                mismatched++;
                $display("FAIL stop_snooze step%0d: got %b want %b", i, obs, e[i]);
            end
        end
    endtask

    task automatic test_alarm_off;
        logic [3:0] s [10] = '{4'b1100, 4'b0110, 4'b0100, 4'b0000, 4'b0000,
                               4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1100};
        logic [5:0] e [10] = '{6'b10_00_00, 6'b01_10_01, 6'b01_01_01, 6'b00_00_01, 6'b00_00_01,
                               6'b00_00_01, 6'b00_00_01, 6'b00_00_01, 6'b00_00_01, 6'b00_00_01};
        for (int i = 0; i < 10; i++) begin
            {buzz_req, alarm_on, snooze, stop} = s[i];
            tick;
            compared++;
            if (obs !== e[i]) begin
                mismatched++;
                $display("FAIL alarm_off step%0d: got %b want %b", i, obs, e[i]);
            end
        end
        buzz_req = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        {buzz_req, alarm_on, snooze, stop} = 4'b1100;
        tick;
        snooze = 1'b1;
        tick;
        snooze = 1'b0;
        compared++;
        if (obs !== 6'b01_10_01) begin
            mismatched++;
            $display("FAIL reset_mid_setup: got %b want %b", obs, 6'b01_10_01);
        end
        rst = 1'b1;
        #1;
        compared++;
        if (obs !== 6'b00_00_00) begin
            mismatched++;
            $display("FAIL reset_mid_async: got %b want %b", obs, 6'b00_00_00);
        end
        tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            compared++;
            if (obs !== 6'b00_00_00) begin
                mismatched++;
                $display("FAIL reset_mid_release step%0d: got %b want %b", i, obs, 6'b00_00_00);
            end
        end
    endtask

    initial begin
        test_reset;
        test_ring_timeout;
        test_snooze;
        test_snooze_limit;
        test_stop_snooze;
        test_alarm_off;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
